// File: rtl/hex_entry_input.sv
// hex_entry_input: debounced switch/button hex word entry with valid/ready output.
// Ports: clk, reset (async active-low), sw, btn_push/clr/enter, data_ready -> data_out, data_valid, preview, digit_cnt.
module hex_entry_input #(
   parameter int DB_CYCLES = 1000000,
   parameter int DB_W      = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  sw,
   input  logic        btn_push,
   input  logic        btn_clr,
   input  logic        btn_enter,
   input  logic        data_ready,
   output logic [31:0] data_out,
   output logic        data_valid,
   output logic [31:0] preview,
   output logic [3:0]  digit_cnt
);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   typedef enum logic {EDIT, HOLD} state_t;

   state_t          state;
   logic [3:0]      sw_s1, sw_s2;
   logic [2:0]      btn_raw, btn_s1, btn_s2;
   logic [2:0]      db_lvl, db_lvl_d, pulse;
   logic [DB_W-1:0] db_cnt [3];
   logic            push_p, clr_p, enter_p;

   // bit 0 push, bit 1 clear, bit 2 enter
   assign btn_raw = {btn_enter, btn_clr, btn_push};
   assign push_p  = pulse[0];
   assign clr_p   = pulse[1];
   assign enter_p = pulse[2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_s1  <= '0;
         sw_s2  <= '0;
         btn_s1 <= '0;
         btn_s2 <= '0;
      end else begin
         sw_s1  <= sw;
         sw_s2  <= sw_s1;
         btn_s1 <= btn_raw;
         btn_s2 <= btn_s1;
      end
   end

   // Level is accepted only after DB_CYCLES consecutive differing samples;
   // any agreeing sample restarts the count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
         db_lvl   <= '0;
         db_lvl_d <= '0;
         pulse    <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (btn_s2[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_lvl[i] <= btn_s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
         db_lvl_d <= db_lvl;
         pulse    <= db_lvl & ~db_lvl_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= EDIT;
         data_out   <= '0;
         data_valid <= 1'b0;
         preview    <= '0;
         digit_cnt  <= '0;
      end else begin
         unique case (state)
            EDIT: begin
               if (clr_p) begin
                  preview   <= '0;
                  digit_cnt <= '0;
               end else if (enter_p) begin
                  data_out   <= preview;
                  data_valid <= 1'b1;
                  state      <= HOLD;
               end else if (push_p) begin
                  preview <= {preview[27:0], sw_s2};
                  if (digit_cnt != 4'd8) digit_cnt <= digit_cnt + 4'd1;
               end
            end
            HOLD: begin
               // push/enter are dropped here; clear only edits the preview
               if (clr_p) begin
                  preview   <= '0;
                  digit_cnt <= '0;
               end
               if (data_ready) begin
                  data_valid <= 1'b0;
                  state      <= EDIT;
               end
            end
            default: state <= EDIT;
         endcase
      end
   end

endmodule

// File: tb/tb_hex_entry_input.sv
// tb_hex_entry_input: directed stimulus against a cycle model of hex_entry_input.
// Checks every cycle plus literal expectations at key points.
module tb_hex_entry_input;

   localparam int DB = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  sw = '0;
   logic        btn_push = 1'b0;
   logic        btn_clr = 1'b0;
   logic        btn_enter = 1'b0;
   logic        data_ready = 1'b0;
   logic [31:0] data_out;
   logic        data_valid;
   logic [31:0] preview;
   logic [3:0]  digit_cnt;

   int checks = 0;
   int errors = 0;
   int lat;

   hex_entry_input #(.DB_CYCLES(DB), .DB_W(3)) dut (
      .clk(clk), .reset(reset), .sw(sw),
      .btn_push(btn_push), .btn_clr(btn_clr), .btn_enter(btn_enter),
      .data_ready(data_ready), .data_out(data_out), .data_valid(data_valid),
      .preview(preview), .digit_cnt(digit_cnt)
   );

   always #5 clk = ~clk;

   // Model: raw history per button; a level flips once the samples
   // 2..DB+1 cycles old all disagree with it. Action lands two edges later.
   logic [DB+1:0] hist [3];
   logic [3:0]    swh [2];
   logic [2:0]    m_lvl = '0, m_rise = '0, m_p = '0;
   logic [31:0]   m_out = '0, m_prev = '0;
   logic          m_valid = 1'b0;
   logic [3:0]    m_cnt = '0;
   logic [2:0]    raw;

   assign raw = {btn_enter, btn_clr, btn_push};

   function automatic logic flips(input logic lvl, input logic [DB+1:0] h);
      return h[DB:1] == {DB{~lvl}};
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 3; i++) hist[i] <= '0;
         swh[0]  <= '0;
         swh[1]  <= '0;
         m_lvl   <= '0;
         m_rise  <= '0;
         m_p     <= '0;
         m_out   <= '0;
         m_prev  <= '0;
         m_valid <= 1'b0;
         m_cnt   <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            hist[i] <= {hist[i][DB:0], raw[i]};
            if (flips(m_lvl[i], hist[i])) m_lvl[i] <= ~m_lvl[i];
            m_rise[i] <= flips(m_lvl[i], hist[i]) & ~m_lvl[i];
         end
         swh[0] <= sw;
         swh[1] <= swh[0];
         m_p    <= m_rise;
         if (m_valid) begin
            if (m_p[1]) begin
               m_prev <= 32'h0;
               m_cnt  <= 4'd0;
            end
            if (data_ready) m_valid <= 1'b0;
         end else if (m_p[1]) begin
            m_prev <= 32'h0;
            m_cnt  <= 4'd0;
         end else if (m_p[2]) begin
            m_out   <= m_prev;
            m_valid <= 1'b1;
         end else if (m_p[0]) begin
            m_prev <= m_prev * 16 + {28'h0, swh[1]};
            m_cnt  <= (m_cnt < 4'd8) ? m_cnt + 4'd1 : 4'd8;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("cyc data_out", data_out, m_out);
         chk("cyc data_valid", {31'h0, data_valid}, {31'h0, m_valid});
         chk("cyc preview", preview, m_prev);
         chk("cyc digit_cnt", {28'h0, digit_cnt}, {28'h0, m_cnt});
      end
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         0: btn_push = v;
         1: btn_clr = v;
         default: btn_enter = v;
      endcase
   endtask

   task automatic press(input int b, input logic [3:0] v);
      sw = v;
      set_btn(b, 1'b1);
      tick(8);
      set_btn(b, 1'b0);
      tick(8);
   endtask

   // cycles until preview moves, bounded at 20
   task automatic wait_prev(output int n);
      logic [31:0] p0;
      p0 = preview;
      n = 0;
      while (n < 20 && preview == p0) begin
         tick(1);
         n++;
      end
   endtask

   initial begin
      tick(3);
      reset = 1'b1;
      chk("rst data_out", data_out, 32'h0);
      chk("rst data_valid", {31'h0, data_valid}, 32'h0);
      chk("rst preview", preview, 32'h0);
      chk("rst digit_cnt", {28'h0, digit_cnt}, 32'h0);
      tick(2);

      // single clean push
      sw = 4'hA;
      btn_push = 1'b1;
      wait_prev(lat);
      chk("push latency", lat, 8);
      tick(10 - lat);
      btn_push = 1'b0;
      tick(10);
      chk("t1 preview", preview, 32'h0000000A);
      chk("t1 digit_cnt", {28'h0, digit_cnt}, 32'd1);

      // bounce shorter than the debounce window
      sw = 4'h5;
      for (int i = 0; i < 10; i++) begin
         btn_push = ~btn_push;
         tick(2);
      end
      btn_push = 1'b0;
      tick(12);
      chk("t2 preview", preview, 32'h0000000A);

      // nine digits then enter
      press(1, 4'h0);
      for (int d = 1; d <= 9; d++) press(0, 4'(d));
      chk("t3 preview", preview, 32'h23456789);
      chk("t3 digit_cnt", {28'h0, digit_cnt}, 32'd8);
      press(2, 4'h0);
      chk("t3 data_valid", {31'h0, data_valid}, 32'd1);
      chk("t3 data_out", data_out, 32'h23456789);

      // hold with no ready; push/enter discarded
      press(0, 4'hF);
      press(2, 4'h0);
      tick(18);
      chk("t4 data_valid", {31'h0, data_valid}, 32'd1);
      chk("t4 data_out", data_out, 32'h23456789);
      chk("t4 preview", preview, 32'h23456789);
      data_ready = 1'b1;
      tick(1);
      data_ready = 1'b0;
      chk("t4 drop valid", {31'h0, data_valid}, 32'd0);
      tick(2);

      // clear and push together, then empty enter
      sw = 4'h7;
      btn_clr = 1'b1;
      btn_push = 1'b1;
      tick(8);
      btn_clr = 1'b0;
      btn_push = 1'b0;
      tick(8);
      chk("t5 preview", preview, 32'h0);
      chk("t5 digit_cnt", {28'h0, digit_cnt}, 32'd0);
      press(2, 4'h0);
      chk("t5 data_valid", {31'h0, data_valid}, 32'd1);
      chk("t5 data_out", data_out, 32'h0);
      data_ready = 1'b1;
      tick(1);
      data_ready = 1'b0;
      tick(2);

      // async reset mid-HOLD and mid-debounce
      press(0, 4'h3);
      press(2, 4'h0);
      chk("t6 pre valid", {31'h0, data_valid}, 32'd1);
      sw = 4'hC;
      btn_push = 1'b1;
      tick(3);
      #2 reset = 1'b0;
      #1;
      chk("t6 async data_out", data_out, 32'h0);
      chk("t6 async valid", {31'h0, data_valid}, 32'd0);
      chk("t6 async preview", preview, 32'h0);
      chk("t6 async digit_cnt", {28'h0, digit_cnt}, 32'd0);
      tick(3);
      reset = 1'b1;
      wait_prev(lat);
      chk("t6 latency", lat, 8);
      chk("t6 preview", preview, 32'h0000000C);
      chk("t6 valid", {31'h0, data_valid}, 32'd0);
      btn_push = 1'b0;
      tick(10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
